// File: rtl/stream_minmax_tracker.sv
// -----------------------------------------------------------------------------
// stream_minmax_tracker
//
// Purpose:
//   Takes a valid/ready stream of unsigned WIDTH-bit samples, groups them into
//   frames of FRAME_LEN accepted beats and, for each frame, reports the minimum,
//   the maximum, the 0-based index of the first occurrence of each, and a flag
//   that is set when every sample in the frame equals the first one. The result
//   is offered on a valid/ready port and held until it is consumed.
//
// Parameters:
//   WIDTH      sample width (unsigned compare)
//   FRAME_LEN  samples per frame, 1..256
//   IDX_W      index width, 2**IDX_W >= FRAME_LEN
//
// Ports:
//   clk          clock, all state changes on posedge
//   rst          synchronous active-high reset
//   clear        synchronous frame abort (drops partial frame or held result)
//   in_valid     sample valid
//   in_ready     block can accept a sample (low while holding a result or in reset)
//   in_data      sample value
//   out_valid    frame result valid
//   out_ready    consumer accepts result
//   out_min      smallest sample of the frame
//   out_max      largest sample of the frame
//   out_min_idx  index of first occurrence of out_min
//   out_max_idx  index of first occurrence of out_max
//   out_all_eq   every sample equals the first sample
// -----------------------------------------------------------------------------
module stream_minmax_tracker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_max_idx,
  output logic             out_all_eq
);

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Magnitude compare returning {gt, lt}; 2'b00 means equal.
  function automatic logic [1:0] mag_cmp(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [1:0] r;
    if (a > b) begin
      r = 2'b10;
    end else if (a < b) begin
      r = 2'b01;
    end else begin
      r = 2'b00;
    end
    return r;
  endfunction

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_min_q;
  logic [WIDTH-1:0] out_max_q;
  logic [IDX_W-1:0] out_min_idx_q;
  logic [IDX_W-1:0] out_max_idx_q;
  logic             out_all_eq_q;

  logic [1:0]       cmp_min_s;
  logic [1:0]       cmp_max_s;
  logic             lt_min_s;
  logic             gt_max_s;
  logic             eq_max_s;
  logic             beat_s;
  logic             consume_s;

  // Ready depends only on state (and is forced low during reset).
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else if (state_q != ST_HOLD) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  // Per-beat compares of the incoming sample against running min and max.
  always_comb begin
    cmp_min_s = mag_cmp(in_data, out_min_q);
    cmp_max_s = mag_cmp(in_data, out_max_q);
    lt_min_s  = cmp_min_s[0];
    gt_max_s  = cmp_max_s[1];
    eq_max_s  = (cmp_max_s == 2'b00);
    beat_s    = in_valid & in_ready;
    consume_s = out_valid_q & out_ready;
  end

  // Frame FSM; the out_* registers double as the running statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FIRST;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_min_q     <= '0;
      out_max_q     <= '0;
      out_min_idx_q <= '0;
      out_max_idx_q <= '0;
      out_all_eq_q  <= 1'b0;
    end else if (clear) begin
      // Abort only: the statistic registers keep whatever they held.
      state_q     <= ST_FIRST;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FIRST: begin
          if (beat_s) begin
            out_min_q     <= in_data;
            out_max_q     <= in_data;
            out_min_idx_q <= '0;
            out_max_idx_q <= '0;
            out_all_eq_q  <= 1'b1;
            cnt_q         <= IDX_ONE;
            if (FRAME_LEN == 1) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_ACCUM;
            end
          end else begin
            state_q <= ST_FIRST;
          end
        end
        ST_ACCUM: begin
          if (beat_s) begin
            // Strict compares so ties keep the first-occurrence index.
            if (lt_min_s) begin
              out_min_q     <= in_data;
              out_min_idx_q <= cnt_q;
            end else begin
              out_min_q     <= out_min_q;
            end
            if (gt_max_s) begin
              out_max_q     <= in_data;
              out_max_idx_q <= cnt_q;
            end else begin
              out_max_q     <= out_max_q;
            end
            out_all_eq_q <= out_all_eq_q & eq_max_s;
            cnt_q        <= cnt_q + IDX_ONE;
            if (cnt_q == LAST_IDX) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_ACCUM;
            end
          end else begin
            state_q <= ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (consume_s) begin
            state_q     <= ST_FIRST;
            out_valid_q <= 1'b0;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q     <= ST_FIRST;
          cnt_q       <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_min     = out_min_q;
  assign out_max     = out_max_q;
  assign out_min_idx = out_min_idx_q;
  assign out_max_idx = out_max_idx_q;
  assign out_all_eq  = out_all_eq_q;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_stream_minmax_tracker
//
// Purpose:
//   Self-checking bench for stream_minmax_tracker (WIDTH=8, FRAME_LEN=16).
//   A table of directed frames with hand-computed results, hand-written
//   sequences for back-pressure, clear and reset, then random frames checked
//   against a reference model that derives min/max/first index/all-equal
//   directly from the whole frame.
// -----------------------------------------------------------------------------
module tb_stream_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_min;
  logic [7:0] out_max;
  logic [7:0] out_min_idx;
  logic [7:0] out_max_idx;
  logic       out_all_eq;

  int vectors     = 0;
  int miscompares = 0;

  typedef logic [15:0][7:0] frame_t;

  typedef struct packed {
    frame_t     s;
    logic [7:0] emin;
    logic [7:0] eminidx;
    logic [7:0] emax;
    logic [7:0] emaxidx;
    logic       eq;
  } vec_t;

  always #5 clk = ~clk;

  stream_minmax_tracker #(.WIDTH(8), .FRAME_LEN(16), .IDX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_min_idx(out_min_idx),
    .out_max_idx(out_max_idx),
    .out_all_eq (out_all_eq)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample (after an optional random idle gap) until accepted.
  task automatic send_beat(input logic [7:0] d, input int max_gap);
    int   gap;
    int   budget;
    logic acc;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 200) begin
      acc = in_ready;
      tick();
      budget++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input frame_t f, input int max_gap);
    for (int i = 0; i < 16; i++) begin
      send_beat(f[i], max_gap);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] emin, input logic [7:0] eminidx,
                              input logic [7:0] emax, input logic [7:0] emaxidx, input logic eq);
    chk({tag, ".out_valid"},   32'(out_valid),   32'd1);
    chk({tag, ".out_min"},     32'(out_min),     32'(emin));
    chk({tag, ".out_min_idx"}, 32'(out_min_idx), 32'(eminidx));
    chk({tag, ".out_max"},     32'(out_max),     32'(emax));
    chk({tag, ".out_max_idx"}, 32'(out_max_idx), 32'(emaxidx));
    chk({tag, ".out_all_eq"},  32'(out_all_eq),  32'(eq));
    chk({tag, ".in_ready"},    32'(in_ready),    32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"},   32'(out_valid),   32'd0);
    chk({tag, ".out_min"},     32'(out_min),     32'd0);
    chk({tag, ".out_max"},     32'(out_max),     32'd0);
    chk({tag, ".out_min_idx"}, 32'(out_min_idx), 32'd0);
    chk({tag, ".out_max_idx"}, 32'(out_max_idx), 32'd0);
    chk({tag, ".out_all_eq"},  32'(out_all_eq),  32'd0);
  endtask

  // Reference: extremes over the whole frame, then first position of each.
  task automatic model(input frame_t f, output logic [7:0] mn, output logic [7:0] mni,
                       output logic [7:0] mx, output logic [7:0] mxi, output logic eq);
    int lo;
    int hi;
    lo = 256;
    hi = -1;
    for (int i = 0; i < 16; i++) begin
      if (int'(f[i]) < lo) lo = int'(f[i]);
      if (int'(f[i]) > hi) hi = int'(f[i]);
    end
    mn  = 8'(lo);
    mx  = 8'(hi);
    mni = 8'd0;
    mxi = 8'd0;
    for (int i = 15; i >= 0; i--) begin
      if (int'(f[i]) == lo) mni = 8'(i);
      if (int'(f[i]) == hi) mxi = 8'(i);
    end
    eq = (lo == hi);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [6];
    frame_t     f;
    logic [7:0] mn, mni, mx, mxi;
    logic       eq;
    int         w;
    int         mode;

    // Directed frames with hand-computed results.
    for (int i = 0; i < 16; i++) begin
      tbl[0].s[i] = 8'(i);
      tbl[1].s[i] = 8'hA5;
      tbl[2].s[i] = 8'h40;
      tbl[3].s[i] = 8'(15 - i);
      tbl[4].s[i] = 8'h40;
      tbl[5].s[i] = 8'h00;
    end
    tbl[2].s[3] = 8'hFF; tbl[2].s[9] = 8'hFF; tbl[2].s[5] = 8'h00; tbl[2].s[12] = 8'h00;
    tbl[4].s[15] = 8'h41;
    tbl[5].s[0]  = 8'h80;
    tbl[0].emin = 8'h00; tbl[0].eminidx = 8'd0;  tbl[0].emax = 8'h0F; tbl[0].emaxidx = 8'd15; tbl[0].eq = 1'b0;
    tbl[1].emin = 8'hA5; tbl[1].eminidx = 8'd0;  tbl[1].emax = 8'hA5; tbl[1].emaxidx = 8'd0;  tbl[1].eq = 1'b1;
    tbl[2].emin = 8'h00; tbl[2].eminidx = 8'd5;  tbl[2].emax = 8'hFF; tbl[2].emaxidx = 8'd3;  tbl[2].eq = 1'b0;
    tbl[3].emin = 8'h00; tbl[3].eminidx = 8'd15; tbl[3].emax = 8'h0F; tbl[3].emaxidx = 8'd0;  tbl[3].eq = 1'b0;
    tbl[4].emin = 8'h40; tbl[4].eminidx = 8'd0;  tbl[4].emax = 8'h41; tbl[4].emaxidx = 8'd15; tbl[4].eq = 1'b0;
    tbl[5].emin = 8'h00; tbl[5].eminidx = 8'd1;  tbl[5].emax = 8'h80; tbl[5].emaxidx = 8'd0;  tbl[5].eq = 1'b0;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    check_zero("reset");
    chk("reset.in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset.in_ready_after", 32'(in_ready), 32'd1);

    // Table frames, back to back with the consumer always ready.
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      send_frame(tbl[t].s, 0);
      check_result($sformatf("tbl%0d", t), tbl[t].emin, tbl[t].eminidx,
                   tbl[t].emax, tbl[t].emaxidx, tbl[t].eq);
    end
    tick();
    chk("tbl.consumed", 32'(out_valid), 32'd0);

    // Back-pressure: result must hold and input must stall for 5 cycles.
    out_ready = 1'b0;
    send_frame(tbl[2].s, 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'h01;
      tick();
      check_result($sformatf("hold%0d", c), 8'h00, 8'd5, 8'hFF, 8'd3, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold.consumed", 32'(out_valid), 32'd0);
    chk("hold.in_ready", 32'(in_ready), 32'd1);
    send_frame(tbl[0].s, 0);
    check_result("after_hold", 8'h00, 8'd0, 8'h0F, 8'd15, 1'b0);

    // Clear after 7 beats; the beat presented with clear is discarded.
    tick();
    for (int i = 0; i < 7; i++) send_beat(8'(i), 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear.out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) f[i] = 8'(100 + i);
    send_frame(f, 0);
    check_result("after_clear", 8'd100, 8'd0, 8'd115, 8'd15, 1'b0);

    // Clear while a result is held drops it but keeps the statistic values.
    tick();
    out_ready = 1'b0;
    send_frame(tbl[1].s, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_hold.out_valid", 32'(out_valid), 32'd0);
    chk("clear_hold.out_min",   32'(out_min),   32'hA5);
    chk("clear_hold.in_ready",  32'(in_ready),  32'd1);

    // Reset mid-frame and again while holding a result.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(8'(50 + i), 0);
    rst = 1'b1;
    tick();
    check_zero("rst_accum");
    chk("rst_accum.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_accum.in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    send_frame(tbl[3].s, 0);
    chk("pre_rst_hold.out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check_zero("rst_hold");
    rst = 1'b0;
    #1;
    chk("rst_hold.in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send_frame(tbl[5].s, 0);
    check_result("after_rst", 8'h00, 8'd1, 8'h80, 8'd0, 1'b0);
    tick();

    // Random frames with input gaps and consumer stalls against the model.
    for (int n = 0; n < 500; n++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) begin
        case (mode)
          0:       f[i] = 8'($urandom);
          1:       f[i] = 8'($urandom_range(0, 3));
          2:       f[i] = 8'h5C;
          default: f[i] = ($urandom_range(0, 2) == 0) ? 8'h00 :
                          ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        endcase
      end
      model(f, mn, mni, mx, mxi, eq);
      out_ready = 1'b0;
      send_frame(f, (n % 2 == 1) ? 3 : 0);
      w = int'($urandom_range(0, 3));
      for (int c = 0; c < w; c++) tick();
      check_result($sformatf("rnd%0d", n), mn, mni, mx, mxi, eq);
      out_ready = 1'b1;
      tick();
      chk($sformatf("rnd%0d.consumed", n), 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
